// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: scan request inputs and decoder-control outputs of the digit scanner
interface digit_scan_ctrl_if;
    logic       run;
    logic [3:0] digit_mask;
    logic       en_n;
    logic       a;
    logic       b;
    logic       slot_done;
    logic       busy;

    modport master (output run, digit_mask, input en_n, a, b, slot_done, busy);
    modport slave  (input run, digit_mask, output en_n, a, b, slot_done, busy);
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexes four digits through a 2-to-4 active-low decoder with per-slot blanking
module digit_scan_ctrl #(
    parameter int PRESCALE = 8,
    parameter int BLANK    = 2,
    parameter int CNT_W    = 16
) (
    input logic              clk,
    input logic              rst_n,
    digit_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] LAST_DRIVE = CNT_W'(PRESCALE - 1);

    state_t           state, state_d;
    logic [1:0]       idx, idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             en_n_q, slot_q, busy_q;
    logic             en_n_d, slot_d, busy_d;
    logic [1:0]       nxt;

    // First enabled digit after cur, searching cur+1 .. cur+4 cyclically
    function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] j;
        next_idx = cur;
        for (int k = 4; k >= 1; k--) begin
            j = cur + k[1:0];
            if (m[j]) next_idx = j;
        end
    endfunction

    assign nxt = next_idx(idx, bus.digit_mask);

    // Next-state logic; the index only moves on entry to BLANK so it never changes while driving
    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt + 1'b1;
        case (state)
            S_IDLE: begin
                cnt_d = cnt;
                if (bus.run && |bus.digit_mask) begin
                    state_d = S_BLANK;
                    idx_d   = nxt;
                    cnt_d   = '0;
                end
            end
            S_BLANK: begin
                if (!bus.run)
                    state_d = S_IDLE;
                else if (cnt == LAST_BLANK)
                    state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (!bus.run)
                    state_d = S_IDLE;
                else if (!bus.digit_mask[idx] || cnt == LAST_DRIVE) begin
                    if (|bus.digit_mask) begin
                        state_d = S_BLANK;
                        idx_d   = nxt;
                        cnt_d   = '0;
                    end else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        en_n_d = state_d != S_DRIVE;
        busy_d = state_d != S_IDLE;
        slot_d = state_d == S_DRIVE && cnt_d == LAST_DRIVE;
    end

    // State and registered outputs; reset parks the index at 3 so the first scan starts at digit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= 2'b11;
            cnt    <= '0;
            en_n_q <= 1'b1;
            slot_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            cnt    <= cnt_d;
            en_n_q <= en_n_d;
            slot_q <= slot_d;
            busy_q <= busy_d;
        end
    end

    assign bus.en_n      = en_n_q;
    assign bus.a         = idx[1];
    assign bus.b         = idx[0];
    assign bus.slot_done = slot_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: scoreboard bench with a slot-position reference model of the digit scanner
module tb_digit_scan_ctrl;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digit_scan_ctrl_if bus();
    digit_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK(BLANK), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int fails = 0;
    logic [4:0] exp_q[$];

    bit m_active = 1'b0;
    int m_idx = 3;
    int m_pos = 0;

    function automatic int nxt(input int cur, input logic [3:0] m);
        for (int k = 1; k <= 4; k++)
            if (m[(cur + k) % 4]) return (cur + k) % 4;
        return cur;
    endfunction

    task automatic step();
        if (!rst_n) begin
            m_active = 1'b0;
            m_idx = 3;
            m_pos = 0;
        end else if (!m_active) begin
            if (bus.run && bus.digit_mask != 4'd0) begin
                m_active = 1'b1;
                m_idx = nxt(m_idx, bus.digit_mask);
                m_pos = 0;
            end
        end else if (!bus.run) begin
            m_active = 1'b0;
        end else if ((m_pos >= BLANK && !bus.digit_mask[m_idx]) || m_pos == PRESCALE - 1) begin
            if (bus.digit_mask != 4'd0) begin
                m_idx = nxt(m_idx, bus.digit_mask);
                m_pos = 0;
            end else
                m_active = 1'b0;
        end else
            m_pos++;
    endtask

    function automatic logic [4:0] expv();
        logic [1:0] i2;
        i2 = m_idx[1:0];
        return {!(m_active && m_pos >= BLANK), i2, m_active && m_pos == PRESCALE - 1, m_active};
    endfunction

    task automatic tick(input logic r, input logic [3:0] m);
        bus.run = r;
        bus.digit_mask = m;
        @(posedge clk);
        step();
        exp_q.push_back(expv());
        #2;
    endtask

    logic [4:0] mon_e, mon_g;
    logic [1:0] prev_ab = 2'b11;

    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_g = {bus.en_n, bus.a, bus.b, bus.slot_done, bus.busy};
            checks++;
            if (mon_g !== mon_e) begin
                fails++;
                $display("FAIL outputs t=%0t {en_n,a,b,slot_done,busy} got=%b exp=%b", $time, mon_g, mon_e);
            end
            checks++;
            if (!bus.en_n && {bus.a, bus.b} != prev_ab) begin
                fails++;
                $display("FAIL glitch t=%0t ab got=%b while driving, previous=%b", $time, {bus.a, bus.b}, prev_ab);
            end
        end
        prev_ab = {bus.a, bus.b};
    end

    task automatic wait_for(input int want_idx, input int want_pos, input string name);
        int n;
        n = 0;
        while (!(m_active && (want_idx < 0 || m_idx == want_idx) && m_pos == want_pos) && n < 100) begin
            tick(1'b1, 4'b1111);
            n++;
        end
        checks++;
        if (n >= 100) begin
            fails++;
            $display("FAIL %s wait expired got idx=%0d pos=%0d exp idx=%0d pos=%0d", name, m_idx, m_pos, want_idx, want_pos);
        end
    endtask

    initial begin
        bus.run = 1'b0;
        bus.digit_mask = 4'd0;
        repeat (3) tick(1'b1, 4'b1111);
        rst_n = 1'b1;
        repeat (70) tick(1'b1, 4'b1111);
        repeat (40) tick(1'b1, 4'b0101);
        wait_for(1, BLANK + 2, "run_drop");
        repeat (5) tick(1'b0, 4'b1111);
        repeat (20) tick(1'b1, 4'b1111);
        wait_for(2, BLANK + 1, "mask_clear");
        repeat (20) tick(1'b1, 4'b1011);
        wait_for(-1, BLANK + 2, "async_rst");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.en_n, bus.a, bus.b, bus.busy} !== 4'b1110) begin
            fails++;
            $display("FAIL async_reset {en_n,a,b,busy} got=%b exp=1110", {bus.en_n, bus.a, bus.b, bus.busy});
        end
        m_active = 1'b0;
        m_idx = 3;
        m_pos = 0;
        repeat (2) tick(1'b1, 4'b1111);
        rst_n = 1'b1;
        repeat (40) tick(1'b1, 4'b1111);
        repeat (60) tick(1'b1, 4'b0000);
        checks++;
        if (bus.en_n !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL mask_zero_idle en_n=%b busy=%b exp en_n=1 busy=0", bus.en_n, bus.busy);
        end
        begin
            logic [3:0] m;
            logic r;
            m = 4'b1111;
            repeat (3000) begin
                r = $urandom_range(0, 15) != 0;
                if ($urandom_range(0, 19) == 0) m = 4'($urandom);
                tick(r, m);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain queue size got=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Sequential scan controller that drives the control inputs of the 2-to-4 active-low decoder (en, a, b) to time-multiplex four digit/row selects.
- Steps a 2-bit digit index through the enabled digits at a prescaled rate.
- Inserts a blanking interval with the decoder disabled before each digit is driven, which prevents ghosting.
- Sits directly upstream of the decoder; its outputs connect one-to-one to the decoder inputs.

Parameters:
- PRESCALE, 8, total clock cycles per digit slot (blank + drive); legal when PRESCALE > BLANK.
- BLANK, 2, cycles at the start of each slot with en_n=1; legal when BLANK >= 1.
- CNT_W, 16, slot counter width; 2^CNT_W must be >= PRESCALE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = scanning enabled.
- digit_mask  in  4  bit i = 1 means digit i takes part in the scan.
- en_n  out  1  decoder enable, active-low (0 = one decoder output asserted low).
- a  out  1  digit index MSB, to decoder a.
- b  out  1  digit index LSB, to decoder b.
- slot_done  out  1  one-cycle pulse on the last drive cycle of a slot.
- busy  out  1  1 while in BLANK or DRIVE.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, en_n=1, {a,b}=2'b11, slot_done=0, busy=0, counter=0.
  - Index 3 at reset means the first scan starts at digit 0.
- All outputs are registered. en_n is never 0 while {a,b} changes: the index updates only on the entry edge to BLANK.
- Next-index function: search cyclically from idx+1 through idx+4 for the first i with digit_mask[i]=1.
  - A single enabled digit yields the same index.
- States:
  - IDLE:
    - en_n=1, busy=0, {a,b} hold.
    - On an edge with run=1 and digit_mask!=0: go to BLANK, load idx=next(idx), counter=0.
  - BLANK:
    - en_n=1, busy=1; counter increments each cycle.
    - When counter==BLANK-1: go to DRIVE.
    - BLANK lasts exactly BLANK cycles.
  - DRIVE:
    - en_n=0, busy=1; counter continues incrementing.
    - When counter==PRESCALE-1: slot_done=1 for that cycle.
      - If run=1 and digit_mask!=0: go to BLANK with idx=next(idx), counter=0.
      - Otherwise go to IDLE.
    - DRIVE lasts exactly PRESCALE-BLANK cycles.
- run deasserted in BLANK or DRIVE:
  - Next edge goes to IDLE and en_n=1 from that edge.
  - slot_done is not pulsed; idx is retained.
- digit_mask is sampled only when computing next(idx).
  - Exception: if digit_mask[idx] becomes 0 during DRIVE, the next edge ends the slot early.
    - en_n=1, slot_done=0.
    - Go to BLANK with the next enabled index, or to IDLE if digit_mask==0.
- digit_mask==0 while run=1 in IDLE: stay in IDLE.
- Decoder-visible output while driving digit i: the decoder output bit i is low, the others high. Mapping {a,b}=00 gives y=1110.

Test Plan (PRESCALE=8, BLANK=2):
- Reset, then run=1, mask=4'b1111:
  - {a,b}=00 with en_n=1 for 2 cycles, then en_n=0 for 6 cycles.
  - slot_done pulses on the 8th cycle.
  - Sequence 00,01,10,11,00 repeats with period 32 cycles.
- mask=4'b0101 while running: the index sequence is 00,10,00,10; digits 1 and 3 are never driven.
- Glitch check across a full scan:
  - No cycle has en_n=0 in the same cycle that {a,b} differs from the previous cycle.
  - Every slot begins with exactly 2 cycles of en_n=1.
- run dropped at the 3rd DRIVE cycle of digit 01:
  - Next edge: en_n=1, busy=0, slot_done never pulses.
  - On run re-asserted, scanning resumes at digit 10.
- mask[2] cleared during the DRIVE of digit 10 (mask becomes 4'b1011):
  - en_n=1 on the next edge, no slot_done pulse.
  - Next slot is digit 11.
- Assert rst_n=0 asynchronously mid-DRIVE: en_n=1, busy=0, {a,b}=11 immediately, without waiting for a clock edge.
- run=1 with mask=0: the block remains in IDLE and en_n stays 1 indefinitely.
